// File: rtl/sound_trigger_array.sv
// Colour/position trigger points: record pixels per slot, then match play-mode pixels and emit the lowest active sound.
// Hit latched 2 cycles after its pixel; sound updates 1 cycle after frame start; no backpressure, pixels accepted every cycle.
module sound_trigger_array #(
  parameter int NUM_PTS = 4,
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int CW      = 8,
  parameter int SW      = 3,
  parameter int TOL     = 24,
  parameter int HOLD    = 2
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               i_state,
  input  logic [SW-1:0]      i_mask,
  input  logic               i_pix_valid,
  input  logic               i_frame_start,
  input  logic               i_clear,
  input  logic [XW-1:0]      i_x,
  input  logic [YW-1:0]      i_y,
  input  logic [CW-1:0]      i_vga_r,
  input  logic [CW-1:0]      i_vga_g,
  input  logic [CW-1:0]      i_vga_b,
  output logic [SW-1:0]      o_sound_num,
  output logic               o_sound_valid,
  output logic [NUM_PTS-1:0] o_armed
);

  localparam int SUMW = CW + 2;
  localparam logic [SUMW-1:0] TOL_C  = SUMW'(TOL);
  localparam logic [2:0]      HOLD_C = 3'(HOLD);

  logic [XW-1:0]      pt_x   [NUM_PTS];
  logic [YW-1:0]      pt_y   [NUM_PTS];
  logic [SUMW-1:0]    pt_sum [NUM_PTS];
  logic [2:0]         cnt      [NUM_PTS];
  logic [2:0]         cnt_next [NUM_PTS];
  logic [NUM_PTS-1:0] armed;
  logic [NUM_PTS-1:0] s1_match;
  logic [NUM_PTS-1:0] hit;
  logic [NUM_PTS-1:0] hit_new;
  logic [NUM_PTS-1:0] active_next;
  logic [SUMW-1:0]    pix_sum;
  logic [SUMW-1:0]    s1_sum;
  logic [SW-1:0]      num_next;

  function automatic logic [SUMW-1:0] abs_diff(input logic [SUMW-1:0] a, input logic [SUMW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    pix_sum = SUMW'(i_vga_r) + SUMW'(i_vga_g) + SUMW'(i_vga_b);
  end

  always_comb begin
    hit_new = '0;
    for (int k = 0; k < NUM_PTS; k++) begin
      hit_new[k] = s1_match[k] && (abs_diff(s1_sum, pt_sum[k]) <= TOL_C);
    end
  end

  // Next-frame counters and winner are resolved combinationally so the sound registers on the frame-start edge.
  always_comb begin
    num_next    = '0;
    active_next = '0;
    for (int k = 0; k < NUM_PTS; k++) begin
      cnt_next[k]    = hit[k] ? ((cnt[k] == HOLD_C) ? HOLD_C : cnt[k] + 3'd1) : 3'd0;
      active_next[k] = armed[k] && (cnt_next[k] == HOLD_C);
    end
    for (int k = NUM_PTS - 1; k >= 0; k--) begin
      if (active_next[k]) num_next = SW'(k + 1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      armed         <= '0;
      s1_match      <= '0;
      s1_sum        <= '0;
      hit           <= '0;
      o_sound_num   <= '0;
      o_sound_valid <= 1'b0;
      for (int k = 0; k < NUM_PTS; k++) begin
        pt_x[k]   <= '0;
        pt_y[k]   <= '0;
        pt_sum[k] <= '0;
        cnt[k]    <= '0;
      end
    end else begin
      if (i_state && i_pix_valid) begin
        for (int k = 0; k < NUM_PTS; k++) begin
          if (i_mask == SW'(k + 1)) begin
            pt_x[k]   <= i_x;
            pt_y[k]   <= i_y;
            pt_sum[k] <= pix_sum;
            armed[k]  <= 1'b1;
          end
        end
      end
      if (i_clear) armed <= '0;

      if (i_state) begin
        s1_match      <= '0;
        s1_sum        <= '0;
        hit           <= '0;
        o_sound_num   <= '0;
        o_sound_valid <= 1'b0;
        for (int k = 0; k < NUM_PTS; k++) cnt[k] <= '0;
      end else begin
        s1_sum <= pix_sum;
        for (int k = 0; k < NUM_PTS; k++) begin
          s1_match[k] <= i_pix_valid && armed[k] && (i_x == pt_x[k]) && (i_y == pt_y[k]);
        end
        o_sound_valid <= 1'b0;
        // A hit arriving on the frame-start edge belongs to the new frame.
        if (i_frame_start) begin
          hit           <= hit_new;
          o_sound_num   <= num_next;
          o_sound_valid <= (num_next != '0) && (num_next != o_sound_num);
          for (int k = 0; k < NUM_PTS; k++) cnt[k] <= cnt_next[k];
        end else begin
          hit <= hit | hit_new;
        end
      end
    end
  end

  assign o_armed = armed;

endmodule

// File: doc/sound_trigger_array.md
SOUND_TRIGGER_ARRAY -- requirements
Module: sound_trigger_array

Interface
REQ-001 SHALL have parameter NUM_PTS, default 4, giving the number of trigger points (1..15).
REQ-002 SHALL have parameter XW, default 10, giving the x coordinate width.
REQ-003 SHALL have parameter YW, default 10, giving the y coordinate width.
REQ-004 SHALL have parameter CW, default 8, giving the width of each colour channel.
REQ-005 SHALL have parameter SW, default 3, giving the sound number width; SW SHALL be at least clog2(NUM_PTS+1).
REQ-006 SHALL have parameter TOL, default 24, giving the colour-sum match tolerance.
REQ-007 SHALL have parameter HOLD, default 2, giving the consecutive frames required to activate a point (1..7).
REQ-008 SHALL have port iCLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-009 SHALL have port iRST_N, input, 1 bit: synchronous, active-low reset.
REQ-010 SHALL have port i_state, input, 1 bit: 1 = record, 0 = play.
REQ-011 SHALL have port i_mask, input, SW bits: 0 = no save; k = save point k (1..NUM_PTS).
REQ-012 SHALL have port i_pix_valid, input, 1 bit: the current pixel is valid.
REQ-013 SHALL have port i_frame_start, input, 1 bit: one-cycle pulse once per frame.
REQ-014 SHALL have port i_clear, input, 1 bit: disarm all points.
REQ-015 SHALL have ports i_x (XW bits) and i_y (YW bits), both inputs: pixel coordinates.
REQ-016 SHALL have ports i_vga_r, i_vga_g and i_vga_b, all inputs, CW bits each: pixel colour.
REQ-017 SHALL have port o_sound_num, output, SW bits: 0 = silence; k = sound of point k.
REQ-018 SHALL have port o_sound_valid, output, 1 bit: one-cycle pulse when a new nonzero sound starts.
REQ-019 SHALL have port o_armed, output, NUM_PTS bits: bit k-1 is set when point k is recorded.

Function
REQ-020 SHALL define colour sum = r+g+b, computed at CW+2 bits with no overflow; stored sums SHALL be CW+2 bits.
REQ-021 SHALL record in record mode: i_state=1, i_pix_valid=1 and 1<=i_mask<=NUM_PTS SHALL store x, y and sum into slot i_mask and set armed[i_mask-1] on the same edge; while the mask is held, the last valid pixel wins.
REQ-022 SHALL ignore an i_mask value of 0 or greater than NUM_PTS, with no state change.
REQ-023 SHALL make i_clear=1 clear all armed bits; i_clear SHALL win over a simultaneous record write; stored coordinates and sums are don't-care.
REQ-024 SHALL use a two-stage play pipeline: stage 1 registers the pixel sum and a one-hot match of armed slots whose stored x,y equal i_x,i_y (valid pixels only); stage 2 sets hit[k] when |sum - stored_sum[k]| <= TOL, using an unsigned absolute difference.
REQ-025 SHALL latch a hit no later than 2 cycles after its pixel.
REQ-026 SHALL handle duplicate coordinates: several slots may match one pixel, and each slot SHALL be evaluated independently.
REQ-027 SHALL update each point on i_frame_start in play mode: cnt[k] increments, saturating at HOLD, if hit[k] was set during the frame; otherwise cnt[k] goes to 0. All hit bits SHALL clear on the same edge.
REQ-028 SHALL treat point k as active when cnt[k]==HOLD and armed[k]=1.
REQ-029 SHALL register o_sound_num one cycle after i_frame_start as the lowest-index active point number, or 0 if none is active; it SHALL hold between frame starts.
REQ-030 SHALL pulse o_sound_valid for exactly one cycle in the same cycle that o_sound_num changes to a nonzero value; a change to 0 SHALL not pulse.
REQ-031 SHALL require the source to keep i_frame_start at least 2 cycles after the last valid pixel; any pixel still in the pipeline at i_frame_start counts toward the next frame.
REQ-032 SHALL, when i_state=1, keep the play pipeline idle, clear all cnt and hit bits, and drive o_sound_num=0 and o_sound_valid=0 from the next cycle.
REQ-033 SHALL leave the arming of the other points unchanged when one point is re-recorded, and SHALL restart that point's cnt at 0.
REQ-034 SHALL take no play action on i_frame_start while in record mode.

Reset
REQ-035 SHALL, when iRST_N=0 at a rising edge, clear all storage, armed bits, hit bits, cnt values and pipeline registers.
REQ-036 SHALL drive o_sound_num=0, o_sound_valid=0 and o_armed=0 from the first edge with iRST_N low.
REQ-037 SHALL give reset priority over all inputs, including mid-frame and mid-record operation.

Verification
REQ-038 SHALL cover record: with defaults, i_state=1, i_mask=2, pixel (100,50) RGB (10,20,30) -> o_armed=4'b0010 the next cycle.
REQ-039 SHALL cover activation: play mode, pixel (100,50) RGB (15,20,30) (diff 5) in two consecutive frames -> o_sound_num=2 one cycle after the 3rd i_frame_start, with a single o_sound_valid pulse.
REQ-040 SHALL cover tolerance: the same pixel with RGB (40,20,30) (diff 30 > 24) every frame -> o_sound_num stays 0 and no pulse.
REQ-041 SHALL cover priority: points 1 and 3 both active -> o_sound_num=1; when point 1 misses a frame -> o_sound_num=3 with a pulse at the next frame start.
REQ-042 SHALL cover clear collision: i_clear=1 in the same cycle as a record to slot 1 -> o_armed=0; a following play frame yields o_sound_num=0.
REQ-043 SHALL cover reset: iRST_N low for one cycle while o_sound_num=2 -> o_sound_num=0 and o_armed=0 at that edge; point 2 is not re-activated without re-recording.
